// File: rtl/idex_ctrl_reg.sv
// ID/EX control-field pipeline register. Inserts all-zero bubbles on load-use
// stalls and for a configurable squash window after a flush, and counts them.
module idex_ctrl_reg #(
  parameter int WB_W         = 2,
  parameter int M_W          = 5,
  parameter int EX_W         = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             id_flush,
  input  logic             ex_hold,
  input  logic             id_valid,
  input  logic [WB_W-1:0]  cntrl_wb,
  input  logic [M_W-1:0]   cntrl_m,
  input  logic [EX_W-1:0]  cntrl_ex,
  output logic [WB_W-1:0]  idex_wb,
  output logic [M_W-1:0]   idex_m,
  output logic [EX_W-1:0]  idex_ex,
  output logic             idex_valid,
  output logic             squash_active,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [3:0] SQ_FULL  = 4'(FLUSH_CYCLES);
  localparam logic [3:0] SQ_AFTER = 4'(FLUSH_CYCLES - 1);

  logic [3:0]      sq_cnt;
  logic [3:0]      sq_next;
  logic            load_bubble;
  logic            load_input;
  logic [WB_W-1:0] wb_next;
  logic [M_W-1:0]  m_next;
  logic [EX_W-1:0] ex_next;
  logic            valid_next;
  logic [CNT_W-1:0] count_next;

  // Priority: hold, flush, open squash window, stall, normal load.
  always_comb begin
    sq_next     = sq_cnt;
    load_bubble = 1'b0;
    load_input  = 1'b0;
    if (ex_hold) begin
      // A flush arriving under hold is parked at the full window length.
      if (id_flush) sq_next = SQ_FULL;
    end else if (id_flush) begin
      load_bubble = 1'b1;
      sq_next     = SQ_AFTER;
    end else if (sq_cnt != 4'd0) begin
      load_bubble = 1'b1;
      sq_next     = sq_cnt - 4'd1;
    end else if (stall) begin
      load_bubble = 1'b1;
    end else begin
      load_input  = 1'b1;
    end
  end

  always_comb begin
    wb_next    = idex_wb;
    m_next     = idex_m;
    ex_next    = idex_ex;
    valid_next = idex_valid;
    count_next = bubble_count;
    if (load_bubble) begin
      wb_next    = '0;
      m_next     = '0;
      ex_next    = '0;
      valid_next = 1'b0;
      if (bubble_count != {CNT_W{1'b1}}) count_next = bubble_count + 1'b1;
    end else if (load_input) begin
      wb_next    = cntrl_wb;
      m_next     = cntrl_m;
      ex_next    = cntrl_ex;
      valid_next = id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_wb      <= '0;
      idex_m       <= '0;
      idex_ex      <= '0;
      idex_valid   <= 1'b0;
      sq_cnt       <= 4'd0;
      bubble_count <= '0;
    end else begin
      idex_wb      <= wb_next;
      idex_m       <= m_next;
      idex_ex      <= ex_next;
      idex_valid   <= valid_next;
      sq_cnt       <= sq_next;
      bubble_count <= count_next;
    end
  end

  assign squash_active = (sq_cnt != 4'd0);

endmodule

// File: tb/tb_idex_ctrl_reg.sv
// Directed bench for idex_ctrl_reg: three instances with different flush
// lengths / counter widths share one stimulus stream.
module tb_idex_ctrl_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, id_flush, ex_hold, id_valid;
  logic [1:0] cntrl_wb;
  logic [4:0] cntrl_m;
  logic [5:0] cntrl_ex;

  logic [1:0] a_wb, b_wb, c_wb;
  logic [4:0] a_m, b_m, c_m;
  logic [5:0] a_ex, b_ex, c_ex;
  logic       a_valid, b_valid, c_valid;
  logic       a_sq, b_sq, c_sq;
  logic [3:0]  a_bc;
  logic [15:0] b_bc, c_bc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idex_ctrl_reg #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_flush(id_flush), .ex_hold(ex_hold),
    .id_valid(id_valid), .cntrl_wb(cntrl_wb), .cntrl_m(cntrl_m), .cntrl_ex(cntrl_ex),
    .idex_wb(a_wb), .idex_m(a_m), .idex_ex(a_ex), .idex_valid(a_valid),
    .squash_active(a_sq), .bubble_count(a_bc));

  idex_ctrl_reg #(.FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_flush(id_flush), .ex_hold(ex_hold),
    .id_valid(id_valid), .cntrl_wb(cntrl_wb), .cntrl_m(cntrl_m), .cntrl_ex(cntrl_ex),
    .idex_wb(b_wb), .idex_m(b_m), .idex_ex(b_ex), .idex_valid(b_valid),
    .squash_active(b_sq), .bubble_count(b_bc));

  idex_ctrl_reg #(.FLUSH_CYCLES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_flush(id_flush), .ex_hold(ex_hold),
    .id_valid(id_valid), .cntrl_wb(cntrl_wb), .cntrl_m(cntrl_m), .cntrl_ex(cntrl_ex),
    .idex_wb(c_wb), .idex_m(c_m), .idex_ex(c_ex), .idex_valid(c_valid),
    .squash_active(c_sq), .bubble_count(c_bc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] wb, input logic [4:0] m, input logic [5:0] ex,
                        input logic v);
    cntrl_wb = wb;
    cntrl_m  = m;
    cntrl_ex = ex;
    id_valid = v;
  endtask

  // Packs dut_a fields as {valid, wb, m, ex}.
  function automatic logic [31:0] a_all();
    return {18'd0, a_valid, a_wb, a_m, a_ex};
  endfunction
  function automatic logic [31:0] b_all();
    return {18'd0, b_valid, b_wb, b_m, b_ex};
  endfunction
  function automatic logic [31:0] c_all();
    return {18'd0, c_valid, c_wb, c_m, c_ex};
  endfunction
  function automatic logic [31:0] pack(input logic v, input logic [1:0] wb,
                                       input logic [4:0] m, input logic [5:0] ex);
    return {18'd0, v, wb, m, ex};
  endfunction

  task automatic do_reset();
    stall = 0; id_flush = 0; ex_hold = 0;
    set_in(2'd0, 5'd0, 6'd0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 0; id_flush = 0; ex_hold = 0;
    set_in(2'd0, 5'd0, 6'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_fields", a_all(), 32'd0);
    chk("rst_a_sq", 32'(a_sq), 32'd0);
    chk("rst_a_bc", 32'(a_bc), 32'd0);
    chk("rst_b_fields", b_all(), 32'd0);
    chk("rst_c_fields", c_all(), 32'd0);
    step();
    rst_n = 1'b1;

    // Plain load, then id_valid=0 still loads fields.
    set_in(2'b11, 5'b10101, 6'b110011, 1'b1);
    step();
    chk("load_a", a_all(), pack(1'b1, 2'b11, 5'b10101, 6'b110011));
    chk("load_a_bc", 32'(a_bc), 32'd0);
    set_in(2'b01, 5'b00110, 6'b101000, 1'b0);
    step();
    chk("load_novalid", a_all(), pack(1'b0, 2'b01, 5'b00110, 6'b101000));
    set_in(2'b11, 5'b10101, 6'b110011, 1'b1);

    // Two-cycle stall.
    stall = 1;
    step();
    chk("stall1_a", a_all(), 32'd0);
    step();
    chk("stall2_a", a_all(), 32'd0);
    stall = 0;
    step();
    chk("stall_end_a", a_all(), pack(1'b1, 2'b11, 5'b10101, 6'b110011));
    chk("stall_bc_a", 32'(a_bc), 32'd2);

    // Flush on FLUSH_CYCLES=3 with stall inside the window.
    id_flush = 1;
    step();
    chk("fl3_b1", a_all(), 32'd0);
    chk("fl3_sq1", 32'(a_sq), 32'd1);
    id_flush = 0;
    stall = 1;
    step();
    chk("fl3_b2", a_all(), 32'd0);
    chk("fl3_sq2", 32'(a_sq), 32'd1);
    stall = 0;
    step();
    chk("fl3_b3", a_all(), 32'd0);
    chk("fl3_sq3", 32'(a_sq), 32'd0);
    chk("fl3_bc", 32'(a_bc), 32'd5);
    step();
    chk("fl3_reload", a_all(), pack(1'b1, 2'b11, 5'b10101, 6'b110011));
    chk("fl3_bc_after", 32'(a_bc), 32'd5);

    // FLUSH_CYCLES=2: flush deferred by a 3-cycle hold.
    do_reset();
    set_in(2'd1, 5'd2, 6'd3, 1'b1);
    step();
    chk("hold_pre_b", b_all(), pack(1'b1, 2'd1, 5'd2, 6'd3));
    set_in(2'd2, 5'd4, 6'd5, 1'b1);
    id_flush = 1;
    ex_hold = 1;
    step();
    chk("hold1_b", b_all(), pack(1'b1, 2'd1, 5'd2, 6'd3));
    chk("hold1_sq_b", 32'(b_sq), 32'd1);
    id_flush = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("hold%0d_b", i + 2), b_all(), pack(1'b1, 2'd1, 5'd2, 6'd3));
    end
    chk("hold_bc_b", 32'(b_bc), 32'd0);
    ex_hold = 0;
    step();
    chk("hold_bub1_b", b_all(), 32'd0);
    chk("hold_bub1_sq_b", 32'(b_sq), 32'd1);
    step();
    chk("hold_bub2_b", b_all(), 32'd0);
    chk("hold_bub2_sq_b", 32'(b_sq), 32'd0);
    step();
    chk("hold_new_b", b_all(), pack(1'b1, 2'd2, 5'd4, 6'd5));
    chk("hold_bc_end_b", 32'(b_bc), 32'd2);

    // Saturation of a 4-bit counter; flush+stall together counts once.
    do_reset();
    set_in(2'b11, 5'b10101, 6'b110011, 1'b1);
    stall = 1;
    id_flush = 1;
    step();
    chk("both_bc_b", 32'(b_bc), 32'd1);
    chk("both_sq_b", 32'(b_sq), 32'd1);
    id_flush = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (i == 14) chk("sat15_a", 32'(a_bc), 32'd15);
    end
    chk("sat20_a", 32'(a_bc), 32'd15);
    chk("sat20_b", 32'(b_bc), 32'd20);
    stall = 0;

    // FLUSH_CYCLES=4: reset mid-window.
    do_reset();
    set_in(2'd3, 5'd7, 6'd9, 1'b1);
    step();
    id_flush = 1;
    step();
    id_flush = 0;
    chk("rstw_pre_sq_c", 32'(c_sq), 32'd1);
    chk("rstw_pre_bc_c", 32'(c_bc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_sq_c", 32'(c_sq), 32'd0);
    chk("rstw_fields_c", c_all(), 32'd0);
    chk("rstw_bc_c", 32'(c_bc), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("rstw_load_c", c_all(), pack(1'b1, 2'd3, 5'd7, 6'd9));
    chk("rstw_bc_after_c", 32'(c_bc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
